stopwatch_counter: RTL and testbench
====================================

# stopwatch_counter

Core timing stage of the stopwatch: divides the system clock to 100 Hz and maintains the 24-bit centisecond count `c` consumed by the seconds/minutes extraction stages. Two push-button inputs, start/stop and lap/reset, drive a four-state control FSM. The FSM handles start, pause, resume, clear, and a lap-hold mode in which the displayed value freezes while timing continues.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency; prescaler divide `DIV = CLK_HZ/100`; must be ≥ 2.
- `WRAP_CS`, default 8_639_999: last count value (23:59:59.99); the next increment returns to 0; must be < 2^24.
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `btn_ss` in 1: start/stop button, asynchronous, assumed debounced.
- `btn_lr` in 1: lap/reset button, asynchronous, assumed debounced.
- `c` out 24: displayed centisecond value, registered.
- `running` out 1: high in RUN and LAP.
- `lap_active` out 1: high in LAP.
- `tick` out 1: one-cycle pulse on each internal count increment.

## Operation
- Each button passes through a 2-flop synchronizer plus a delay flop; a rising edge gives a one-cycle pulse (`ss_p`, `lr_p`).
- Internal registers: `cnt` [23:0] (live count), `pre` (0..DIV-1), `hold` [23:0] (lap capture).
- States:
  - IDLE:
    - `cnt = 0`, `pre = 0`.
    - `ss_p` → RUN.
    - `lr_p` ignored.
  - RUN:
    - Prescaler and count advance.
    - `ss_p` → PAUSE.
    - `lr_p` → LAP, and `hold <= cnt` (value before any same-cycle increment).
  - LAP:
    - Counting continues exactly as in RUN.
    - `lr_p` → RUN.
    - `ss_p` → PAUSE; the display reverts to live `cnt`.
  - PAUSE:
    - `pre` and `cnt` are frozen; the prescaler is not cleared, so sub-centisecond phase is kept.
    - `ss_p` → RUN.
    - `lr_p` → IDLE, clearing `cnt` and `pre`.
- Simultaneous `ss_p` and `lr_p` in one cycle: `ss_p` wins and `lr_p` is discarded.
- Prescaler, in RUN/LAP only:
  - When `pre == DIV-1`, then `pre <= 0`, `tick <= 1`, and `cnt <= (cnt == WRAP_CS) ? 0 : cnt+1`.
  - Otherwise `pre <= pre+1` and `tick <= 0`.
- Output mux, registered:
  - In LAP, `c <= hold`.
  - Otherwise `c <= next cnt`, so `c` equals `cnt` in the same cycle.
- No arithmetic beyond +1 and compare. `cnt` never exceeds `WRAP_CS`.

## Timing
- Reset values: state IDLE; `cnt`, `pre`, `hold`, `c` = 0; `running`, `lap_active`, `tick` = 0; all synchronizer flops = 0.
- Button latency: a button first sampled high at edge N gives a pulse during cycle N+1..N+2. The state change and outputs update at edge N+2.
- A button held high produces exactly one pulse. Release has no effect.
- Increment spacing: exactly DIV cycles between `tick` pulses while running.
- First `tick` after IDLE→RUN arrives DIV cycles after the transition edge.
- `tick`, `cnt`, and `c` update on the same edge.
- A `ss_p` into PAUSE arriving in the same cycle as `pre == DIV-1`: the state transition takes effect and the increment is suppressed (PAUSE wins).
- `rst` asserted mid-count: all registers clear immediately. After deassertion the block sits in IDLE and waits for `btn_ss`.
- `c` is stable between rising edges, so falling-edge consumers sample it safely.

## Structure
- Shared package `stopwatch_pkg`:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, LAP=2'd2, PAUSE=2'd3.
  - `CS_PER_SEC = 100`.
  - `CS_WIDTH = 24`.
  - Default `WRAP_CS`.
- Sub-module `btn_edge_sync` (synchronizer + rising-edge pulse), instantiated once per button.
- Top level holds the FSM, prescaler, count, and output registers.

## Test plan
- Reset then run (CLK_HZ=1000, DIV=10):
  - Pulse `btn_ss` → `running` = 1 at edge N+2.
  - First `tick` 10 cycles later, `c` = 1.
  - After 100 further cycles, `c` = 11.
- Pause/resume:
  - Stop at `c` = 25, wait 500 cycles → `c` stays 25 and `tick` stays 0.
  - Resume → next increment arrives after the remaining `DIV - pre` cycles.
- Lap:
  - In RUN at `c` = 40, pulse `btn_lr` → `c` holds 40 and `lap_active` = 1 while internal count advances.
  - Second `btn_lr` 50 cycles later → `c` jumps to 45.
- Clear:
  - In PAUSE with `c` = 77, pulse `btn_lr` → IDLE, `c` = 0.
  - Next `btn_ss` → first `tick` after a full 10 cycles.
- Wrap and collisions:
  - With `WRAP_CS` = 5, run → `c` sequence 1, 2, 3, 4, 5, 0, 1.
  - Both buttons pulsed in the same cycle while in RUN → PAUSE, `lap_active` stays 0.
- Async reset:
  - Assert `rst` mid-cycle during LAP with `c` = 300 → all outputs 0 immediately, before the next edge.
  - State IDLE after release.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timing stages.
package stopwatch_pkg;

    // Control FSM encoding; downstream stages rely on these exact values.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        LAP   = 2'd2,
        PAUSE = 2'd3
    } state_t;

    localparam int unsigned CS_PER_SEC      = 100;
    localparam int unsigned CS_WIDTH        = 24;
    // 23:59:59.99 expressed in centiseconds.
    localparam int unsigned DEFAULT_WRAP_CS = 8_639_999;

    // Centisecond successor with wrap back to zero after the last value.
    function automatic logic [CS_WIDTH-1:0] cs_next(input logic [CS_WIDTH-1:0] cs,
                                                   input logic [CS_WIDTH-1:0] wrap);
        return (cs == wrap) ? '0 : cs + CS_WIDTH'(1);
    endfunction

endpackage

// File: rtl/stopwatch_counter_btn_edge_sync.sv
// Two-flop synchronizer plus delay flop; emits a one-cycle pulse on a rising edge.
module btn_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_pulse
);

    logic r_sync1;
    logic r_sync2;
    logic r_dly;

    // Synchronize the asynchronous button and keep one cycle of history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_dly   <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_dly   <= r_sync2;
        end
    end

    // High for exactly one cycle after a synchronized low-to-high transition.
    assign o_pulse = r_sync2 & ~r_dly;

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch core: 100 Hz prescaler, centisecond count, lap hold and control FSM.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned WRAP_CS = DEFAULT_WRAP_CS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_ss,
    input  logic                btn_lr,
    output logic [CS_WIDTH-1:0] c,
    output logic                running,
    output logic                lap_active,
    output logic                tick
);

    localparam int unsigned DIV    = CLK_HZ / CS_PER_SEC;
    localparam int unsigned PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [CS_WIDTH-1:0] WRAP_V   = CS_WIDTH'(WRAP_CS);

    state_t              r_state;
    logic [CS_WIDTH-1:0] r_cnt;
    logic [PRE_W-1:0]    r_pre;
    logic [CS_WIDTH-1:0] r_hold;
    logic [CS_WIDTH-1:0] r_c;
    logic                r_running;
    logic                r_lap;
    logic                r_tick;

    logic                w_ss_p;
    logic                w_lr_p;
    logic                w_pre_last;
    logic [PRE_W-1:0]    w_pre_adv;
    logic [CS_WIDTH-1:0] w_cnt_adv;

    btn_edge_sync u_sync_ss (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_ss),
        .o_pulse (w_ss_p)
    );

    btn_edge_sync u_sync_lr (
        .clk     (clk),
        .rst     (rst),
        .i_btn   (btn_lr),
        .o_pulse (w_lr_p)
    );

    // Values the prescaler and count take if this cycle is allowed to advance.
    always_comb begin
        w_pre_last = (r_pre == PRE_LAST);
        w_pre_adv  = w_pre_last ? '0 : r_pre + PRE_W'(1);
        w_cnt_adv  = w_pre_last ? cs_next(r_cnt, WRAP_V) : r_cnt;
    end

    // Control FSM with prescaler, live count, lap capture and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_pre     <= '0;
            r_hold    <= '0;
            r_c       <= '0;
            r_running <= 1'b0;
            r_lap     <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt  <= '0;
                    r_pre  <= '0;
                    r_c    <= '0;
                    r_tick <= 1'b0;
                    if (w_ss_p) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end
                end

                RUN: begin
                    if (w_ss_p) begin
                        // Pausing suppresses any increment due this cycle.
                        r_state   <= PAUSE;
                        r_running <= 1'b0;
                        r_tick    <= 1'b0;
                        r_c       <= r_cnt;
                    end else begin
                        r_pre  <= w_pre_adv;
                        r_cnt  <= w_cnt_adv;
                        r_tick <= w_pre_last;
                        if (w_lr_p) begin
                            // Capture the pre-increment value for the frozen display.
                            r_state <= LAP;
                            r_lap   <= 1'b1;
                            r_hold  <= r_cnt;
                            r_c     <= r_cnt;
                        end else begin
                            r_c <= w_cnt_adv;
                        end
                    end
                end

                LAP: begin
                    if (w_ss_p) begin
                        r_state   <= PAUSE;
                        r_running <= 1'b0;
                        r_lap     <= 1'b0;
                        r_tick    <= 1'b0;
                        r_c       <= r_cnt;
                    end else begin
                        r_pre  <= w_pre_adv;
                        r_cnt  <= w_cnt_adv;
                        r_tick <= w_pre_last;
                        if (w_lr_p) begin
                            r_state <= RUN;
                            r_lap   <= 1'b0;
                            r_c     <= w_cnt_adv;
                        end else begin
                            r_c <= r_hold;
                        end
                    end
                end

                PAUSE: begin
                    // Prescaler phase is retained so resume finishes the partial period.
                    r_tick <= 1'b0;
                    if (w_ss_p) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                        r_c       <= r_cnt;
                    end else if (w_lr_p) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_pre   <= '0;
                        r_c     <= '0;
                    end
                end

                default: begin
                    r_state   <= IDLE;
                    r_cnt     <= '0;
                    r_pre     <= '0;
                    r_c       <= '0;
                    r_running <= 1'b0;
                    r_lap     <= 1'b0;
                    r_tick    <= 1'b0;
                end
            endcase
        end
    end

    assign c          = r_c;
    assign running    = r_running;
    assign lap_active = r_lap;
    assign tick       = r_tick;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Self-checking bench: two stopwatch instances (full-day wrap and wrap at 5) against
// an elapsed-cycle reference model.
module tb_stopwatch_counter;

    localparam int CLK_HZ = 1000;
    localparam int DIV    = CLK_HZ / 100;
    localparam int WRAP_A = 8_639_999;
    localparam int WRAP_B = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_ss = 1'b0;
    logic        btn_lr = 1'b0;
    logic [23:0] c_a, c_b;
    logic        run_a, run_b, lap_a, lap_b, tick_a, tick_b;

    int checks = 0;
    int failures = 0;

    // Reference model: mode 0 idle, 1 run, 2 lap, 3 pause. Time is kept as the
    // number of running cycles since the last clear; the count is derived from it.
    int m_mode = 0;
    int m_ph = 0;
    int m_hold = 0;
    bit m_tick = 1'b0;
    bit ss_h1 = 0, ss_h2 = 0, ss_h3 = 0;
    bit lr_h1 = 0, lr_h2 = 0, lr_h3 = 0;

    stopwatch_counter #(.CLK_HZ(CLK_HZ), .WRAP_CS(WRAP_A)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_ss     (btn_ss),
        .btn_lr     (btn_lr),
        .c          (c_a),
        .running    (run_a),
        .lap_active (lap_a),
        .tick       (tick_a)
    );

    stopwatch_counter #(.CLK_HZ(CLK_HZ), .WRAP_CS(WRAP_B)) dut_wrap (
        .clk        (clk),
        .rst        (rst),
        .btn_ss     (btn_ss),
        .btn_lr     (btn_lr),
        .c          (c_b),
        .running    (run_b),
        .lap_active (lap_b),
        .tick       (tick_b)
    );

    always #5 clk = ~clk;

    function automatic int cs_of(input int ph, input int wrap);
        return (ph / DIV) % (wrap + 1);
    endfunction

    function automatic int disp(input int wrap);
        return (m_mode == 2) ? cs_of(m_hold, wrap) : cs_of(m_ph, wrap);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_ph = 0; m_hold = 0; m_tick = 1'b0;
        ss_h1 = 0; ss_h2 = 0; ss_h3 = 0;
        lr_h1 = 0; lr_h2 = 0; lr_h3 = 0;
    endtask

    // Apply one rising edge to the model, using button samples from earlier edges.
    task automatic model_edge();
        bit ss_p, lr_p;
        ss_p = ss_h2 & ~ss_h3;
        lr_p = lr_h2 & ~lr_h3;
        m_tick = 1'b0;
        case (m_mode)
            0: if (ss_p) begin m_mode = 1; m_ph = 0; end
            1, 2: begin
                if (ss_p) m_mode = 3;
                else begin
                    m_tick = ((m_ph % DIV) == DIV - 1);
                    if (lr_p && m_mode == 1) begin m_hold = m_ph; m_mode = 2; end
                    else if (lr_p) m_mode = 1;
                    m_ph = m_ph + 1;
                end
            end
            default: begin
                if (ss_p) m_mode = 1;
                else if (lr_p) begin m_mode = 0; m_ph = 0; end
            end
        endcase
        ss_h3 = ss_h2; ss_h2 = ss_h1; ss_h1 = btn_ss;
        lr_h3 = lr_h2; lr_h2 = lr_h1; lr_h1 = btn_lr;
    endtask

    task automatic check_all();
        chk("c_full", {8'd0, c_a}, disp(WRAP_A));
        chk("c_wrap5", {8'd0, c_b}, disp(WRAP_B));
        chk("running", {31'd0, run_a}, (m_mode == 1 || m_mode == 2) ? 1 : 0);
        chk("lap_active", {31'd0, lap_a}, (m_mode == 2) ? 1 : 0);
        chk("tick", {31'd0, tick_a}, {31'd0, m_tick});
        chk("running_w5", {31'd0, run_b}, {31'd0, run_a});
        chk("tick_w5", {31'd0, tick_b}, {31'd0, m_tick});
        chk("lap_w5", {31'd0, lap_b}, (m_mode == 2) ? 1 : 0);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic press(input bit ss, input bit lr, input int hold, input int gap);
        btn_ss = ss;
        btn_lr = lr;
        cycles(hold);
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        cycles(gap);
    endtask

    // Advance until the model's full-range display reaches target, with a cycle budget.
    task automatic run_until(input int target, input int budget);
        int n;
        n = 0;
        while (disp(WRAP_A) != target && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (disp(WRAP_A) != target) begin
            failures++;
            $error("FAIL run_until observed=%0d expected=%0d", disp(WRAP_A), target);
        end
    endtask

    initial begin
        // Power-on reset.
        repeat (3) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cycles(4);

        // Start, first tick, extended run.
        press(1, 0, 1, 12);
        cycles(100);

        // Pause near 25 and hold for 500 cycles, then resume mid-period.
        run_until(23, 200);
        press(1, 0, 3, 500);
        press(1, 0, 1, 40);

        // Lap hold around 40, release after 50 cycles.
        run_until(38, 400);
        press(0, 1, 2, 50);
        press(0, 1, 1, 20);

        // Pause, clear to idle, restart.
        press(1, 0, 1, 30);
        press(0, 1, 1, 10);
        press(1, 0, 1, 30);

        // Both buttons at once while running: stop wins.
        press(1, 1, 1, 20);
        press(1, 0, 1, 30);

        // Async reset mid-cycle while in lap with a non-zero display.
        press(0, 1, 1, 25);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("rst_c_zero", {8'd0, c_a}, 0);
        #2 rst = 1'b0;
        cycles(20);
        press(0, 1, 1, 10);
        press(1, 0, 1, 80);

        // Random button activity, including simultaneous presses and long holds.
        for (int k = 0; k < 150; k++) begin
            int sel;
            sel = $urandom_range(0, 9);
            press(sel < 5 ? 1'b1 : (sel == 9), sel >= 5,
                  $urandom_range(1, 6), $urandom_range(3, 60));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
